cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the single common data bus (CDB) among the functional units of the Tomasulo core: ALU, load/store buffer and branch unit. Each unit pushes finished results (ROB tag, value, extra info) into a private 2-entry FIFO inside the block. A round-robin arbiter broadcasts at most one result per cycle to the reservation station, load/store buffer and reorder buffer. All in-flight results are dropped on ROB rollback.

## Interface
Parameters:
- NUM_REQ, 3, number of requesting units; index 0 = ALU, 1 = LSB, 2 = branch unit
- TAG_WIDTH, 4, ROB tag width; tag 0 is the null tag
- DATA_WIDTH, 32, result value width
- EXTRA_WIDTH, 33, opaque sideband (bit 32 = branch taken, [31:0] = target PC), passed through unchanged

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rob_rollback_in  in  1  misprediction flush
- req_valid_in  in  NUM_REQ  per-unit result valid
- req_tag_in  in  NUM_REQ*TAG_WIDTH  per-unit ROB tag, unit i at [i*TAG_WIDTH +: TAG_WIDTH]
- req_data_in  in  NUM_REQ*DATA_WIDTH  per-unit value, packed the same way
- req_extra_in  in  NUM_REQ*EXTRA_WIDTH  per-unit sideband, packed the same way
- req_ready_out  out  NUM_REQ  per-unit FIFO can accept
- cdb_valid_out  out  1  broadcast valid
- cdb_tag_out  out  TAG_WIDTH  broadcast ROB tag
- cdb_data_out  out  DATA_WIDTH  broadcast value
- cdb_extra_out  out  EXTRA_WIDTH  broadcast sideband
- cdb_src_out  out  clog2(NUM_REQ)  index of the granted unit

## Operation
- **Per-unit FIFO:** depth 2, holding {tag, data, extra}. Pointers are 1 bit. Count is 0..2.
- **Ready:** req_ready_out[i] = (count_i < 2). It is derived only from registered state; there is no path from valid to ready.
- **Push:** occurs when req_valid_in[i] && req_ready_out[i] at the clock edge. A push while ready is low is a protocol violation; the bench asserts it never happens.
- **Arbitration:** combinational over non-empty FIFO heads.
  - Scan starts at pointer p: p, p+1, … with wrap modulo NUM_REQ. The first non-empty head is granted (g).
  - On a grant, the head of FIFO g is popped and p <= (g+1) mod NUM_REQ.
  - With no grant, p is unchanged.
- **Output register:** at each edge, cdb_valid_out <= grant_any and cdb_tag/data/extra/src <= the granted head. When there is no grant, payload outputs hold their previous values and only valid drops.
- **Same-cycle push and pop on one FIFO:** count is unchanged; both operations take effect.
- **Rollback:** rob_rollback_in high in cycle c. At the edge ending c:
  - all counts and pointers are cleared;
  - cdb_valid_out <= 0;
  - pushes and the grant of cycle c are discarded;
  - p is kept.
  - The broadcast already visible during c is not retracted; consumers handle it under their own rollback.
- **rst:** as rollback, and additionally p <= 0 and all payload outputs are set to 0.
- **rst and rob_rollback_in together:** rst wins.
- **Null-tag results:** no special treatment. Units never send tag 0; this is a bench assertion.

## Timing
- **Reset values:** cdb_valid_out 0, cdb_tag_out 0, cdb_data_out 0, cdb_extra_out 0, cdb_src_out 0. req_ready_out is all ones in the cycle after reset.
- **Latency:**
  - A push accepted at the edge ending cycle c is eligible for arbitration in c+1.
  - With no contention it is broadcast in c+2, which is 2 cycles.
- **Throughput:**
  - Aggregate: 1 broadcast per cycle.
  - A single uncontended unit sustains 1 push per cycle, with count settling at 1.
- **Worst-case wait:** with all units saturated, a non-empty head waits at most NUM_REQ-1 cycles before its grant.
- **Back-pressure:** ready falls in the cycle after count reaches 2 and rises in the cycle after a pop.

## Structure
- The shared header holds the tag range, word range, null tag and NUM_REQ unit indices. No new typedefs.
- One natural sub-module: cdb_req_fifo, a 2-entry FIFO with synchronous flush, instantiated NUM_REQ times.
- The arbiter and output register are in the top level.

## Test plan
- **Reset:** hold rst 3 cycles with all req_valid_in=1 -> cdb_valid_out=0 and outputs 0 throughout; the cycle after rst drops, req_ready_out=3'b111.
- **Single unit:** ALU pushes tag 5, data 0x1234 in cycle 10 -> cycle 12 shows cdb_valid_out=1, tag 5, data 0x1234, src 0.
- **Round-robin:**
  - All three units push one result each in cycle 0 -> broadcasts in cycles 2, 3, 4 with src 0, 1, 2.
  - Starting with p=1 -> order 1, 2, 0.
- **Saturation:**
  - Units 0 and 1 each push every cycle for 10 cycles, stalling when ready is low.
  - Expected: src alternates 0, 1, 0, 1; ready of each unit drops; no result is lost or duplicated; the scoreboard matches all 20 tags in per-unit order.
- **Rollback:**
  - Fill FIFOs (counts 2, 2, 1), then assert rob_rollback_in for one cycle.
  - Expected: cdb_valid_out=0 next cycle and stays 0 with no new pushes; req_ready_out=3'b111; none of the flushed tags ever appear.
- **rst mid-stream:** rst asserted together with a rollback and a pending push -> state identical to the reset test; p=0, so the first post-reset grant goes to unit 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: field widths, null tag and unit indices.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 3;
  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_EXTRA_W = 33;

  localparam logic [CDB_TAG_W-1:0] CDB_NULL_TAG = '0;

  localparam int UNIT_ALU = 0;
  localparam int UNIT_LSB = 1;
  localparam int UNIT_BRU = 2;

endpackage

// File: rtl/cdb_req_fifo.sv
// Two-entry result FIFO for one functional unit; flush empties it synchronously.
module cdb_req_fifo #(
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign ready = (count < 2'd2);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among functional units, one registered broadcast per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = CDB_NUM_REQ,
  parameter int TAG_WIDTH   = CDB_TAG_W,
  parameter int DATA_WIDTH  = CDB_DATA_W,
  parameter int EXTRA_WIDTH = CDB_EXTRA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rob_rollback_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
  input  logic [NUM_REQ*EXTRA_WIDTH-1:0] req_extra_in,
  output logic [NUM_REQ-1:0]             req_ready_out,
  output logic                           cdb_valid_out,
  output logic [TAG_WIDTH-1:0]           cdb_tag_out,
  output logic [DATA_WIDTH-1:0]          cdb_data_out,
  output logic [EXTRA_WIDTH-1:0]         cdb_extra_out,
  output logic [$clog2(NUM_REQ)-1:0]     cdb_src_out
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int ENT_W = TAG_WIDTH + DATA_WIDTH + EXTRA_WIDTH;

  logic [ENT_W-1:0]   head [NUM_REQ];
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     scan;
  logic               grant_any;
  logic               flush;

  // Flush also discards any push or pop of the same cycle.
  assign flush = rst | rob_rollback_in;
  assign push  = req_valid_in & req_ready_out;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    assign pop[i] = grant_any && (grant_idx == SRC_W'(i));

    cdb_req_fifo #(.WIDTH(ENT_W)) u_fifo (
      .clk   (clk),
      .flush (flush),
      .push  (push[i]),
      .wdata ({req_tag_in[i*TAG_WIDTH +: TAG_WIDTH],
               req_data_in[i*DATA_WIDTH +: DATA_WIDTH],
               req_extra_in[i*EXTRA_WIDTH +: EXTRA_WIDTH]}),
      .pop   (pop[i]),
      .rdata (head[i]),
      .empty (empty[i]),
      .ready (req_ready_out[i])
    );
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan >= (SRC_W+1)'(NUM_REQ)) scan = scan - (SRC_W+1)'(NUM_REQ);
      if (!grant_any && !empty[scan[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[SRC_W-1:0];
      end
    end
  end

  // Rollback keeps the round-robin pointer and the last payload; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      cdb_valid_out <= 1'b0;
      cdb_tag_out   <= TAG_WIDTH'(CDB_NULL_TAG);
      cdb_data_out  <= '0;
      cdb_extra_out <= '0;
      cdb_src_out   <= '0;
    end else if (rob_rollback_in) begin
      cdb_valid_out <= 1'b0;
    end else begin
      cdb_valid_out <= grant_any;
      if (grant_any) begin
        {cdb_tag_out, cdb_data_out, cdb_extra_out} <= head[grant_idx];
        cdb_src_out <= grant_idx;
        rr_ptr      <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model compared every cycle plus directed literal checks.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int EW = 33;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rob_rollback_in = 1'b0;
  logic [N-1:0]    req_valid_in = '0;
  logic [N*TW-1:0] req_tag_in = '0;
  logic [N*DW-1:0] req_data_in = '0;
  logic [N*EW-1:0] req_extra_in = '0;
  logic [N-1:0]    req_ready_out;
  logic            cdb_valid_out;
  logic [TW-1:0]   cdb_tag_out;
  logic [DW-1:0]   cdb_data_out;
  logic [EW-1:0]   cdb_extra_out;
  logic [1:0]      cdb_src_out;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .EXTRA_WIDTH(EW)) dut (
    .clk             (clk),
    .rst             (rst),
    .rob_rollback_in (rob_rollback_in),
    .req_valid_in    (req_valid_in),
    .req_tag_in      (req_tag_in),
    .req_data_in     (req_data_in),
    .req_extra_in    (req_extra_in),
    .req_ready_out   (req_ready_out),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_tag_out     (cdb_tag_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_extra_out   (cdb_extra_out),
    .cdb_src_out     (cdb_src_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [EW-1:0] extra;
  } res_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } mon_t;

  // Reference model: each unit is a queue of at most two results, one grant per cycle.
  res_t mq[N][$];
  int   mp;
  logic m_valid;
  res_t m_res;
  int   m_src;
  bit   model_ok = 1'b0;

  initial begin : model_proc
    bit   rdy [N];
    int   g;
    res_t r;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < 2);
      if (rst) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        mp = 0; m_valid = 1'b0; m_res = '0; m_src = 0; model_ok = 1'b1;
      end else if (model_ok) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid_in[i]) begin
            checks++;
            if (!rdy[i]) begin
              errors++;
              $display("FAIL push_protocol unit %0d actual ready=0 required ready=1", i);
            end
            checks++;
            if (req_tag_in[i*TW +: TW] == CDB_NULL_TAG) begin
              errors++;
              $display("FAIL null_tag unit %0d actual tag=0 required nonzero", i);
            end
          end
        end
        if (rob_rollback_in) begin
          for (int i = 0; i < N; i++) mq[i].delete();
          m_valid = 1'b0;
        end else begin
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && mq[(mp + k) % N].size() > 0) g = (mp + k) % N;
          m_valid = (g >= 0);
          if (g >= 0) begin
            m_res = mq[g].pop_front();
            m_src = g;
            mp    = (g + 1) % N;
          end
          for (int i = 0; i < N; i++) begin
            if (req_valid_in[i] && rdy[i]) begin
              r.tag   = req_tag_in[i*TW +: TW];
              r.data  = req_data_in[i*DW +: DW];
              r.extra = req_extra_in[i*EW +: EW];
              mq[i].push_back(r);
            end
          end
        end
      end
    end
  end

  initial begin : compare_proc
    logic [N-1:0] er;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int i = 0; i < N; i++) er[i] = (mq[i].size() < 2);
        chk("model_ready", 64'(req_ready_out), 64'(er));
        chk("model_valid", 64'(cdb_valid_out), 64'(m_valid));
        chk("model_tag",   64'(cdb_tag_out),   64'(m_res.tag));
        chk("model_data",  64'(cdb_data_out),  64'(m_res.data));
        chk("model_extra", 64'(cdb_extra_out), 64'(m_res.extra));
        chk("model_src",   64'(cdb_src_out),   64'(m_src));
      end
    end
  end

  bit   mon_en = 1'b0;
  mon_t mon_q[$];

  initial forever begin
    @(negedge clk);
    if (mon_en && cdb_valid_out) mon_q.push_back({cdb_src_out, cdb_tag_out, cdb_data_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid_in[u]         = 1'b1;
    req_tag_in[u*TW +: TW]  = t;
    req_data_in[u*DW +: DW] = d;
    req_extra_in[u*EW +: EW] = {d[0], d ^ 32'hA5A5_0000};
  endtask

  task automatic idle();
    req_valid_in = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main_proc
    int   exp_src [3];
    int   s [2];
    bit   saw_low [2];
    int   n [2];
    int   iter;
    bit   alt;
    logic [TW-1:0] rb_tags [4];

    // Reset held with all units offering results
    rst = 1'b1;
    drive(UNIT_ALU, 4'd1, 32'h101);
    drive(UNIT_LSB, 4'd2, 32'h102);
    drive(UNIT_BRU, 4'd3, 32'h103);
    repeat (3) begin
      tick();
      chk("rst_valid", 64'(cdb_valid_out), 64'd0);
      chk("rst_tag",   64'(cdb_tag_out),   64'd0);
      chk("rst_data",  64'(cdb_data_out),  64'd0);
      chk("rst_extra", 64'(cdb_extra_out), 64'd0);
      chk("rst_src",   64'(cdb_src_out),   64'd0);
    end
    rst = 1'b0;
    idle();
    chk("rst_ready", 64'(req_ready_out), 64'b111);

    // Single ALU result: broadcast two cycles later
    drive(UNIT_ALU, 4'd5, 32'h1234);
    tick(); idle(); tick();
    chk("single_valid", 64'(cdb_valid_out), 64'd1);
    chk("single_tag",   64'(cdb_tag_out),   64'd5);
    chk("single_data",  64'(cdb_data_out),  64'h1234);
    chk("single_src",   64'(cdb_src_out),   64'd0);
    tick();

    // Round robin with pointer at 1
    exp_src = '{1, 2, 0};
    drive(UNIT_ALU, 4'd6, 32'h61);
    drive(UNIT_LSB, 4'd7, 32'h71);
    drive(UNIT_BRU, 4'd8, 32'h81);
    tick(); idle(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("rr1_valid", 64'(cdb_valid_out), 64'd1);
      chk("rr1_src",   64'(cdb_src_out),   64'(exp_src[k]));
      chk("rr1_tag",   64'(cdb_tag_out),   64'(6 + exp_src[k]));
      tick();
    end

    drive(UNIT_BRU, 4'd9, 32'h91);
    tick(); idle(); tick();
    chk("bru_src", 64'(cdb_src_out), 64'd2);
    chk("bru_tag", 64'(cdb_tag_out), 64'd9);
    tick();

    // Round robin with pointer back at 0
    exp_src = '{0, 1, 2};
    drive(UNIT_ALU, 4'd10, 32'hA1);
    drive(UNIT_LSB, 4'd11, 32'hB1);
    drive(UNIT_BRU, 4'd12, 32'hC1);
    tick(); idle(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("rr0_src", 64'(cdb_src_out), 64'(exp_src[k]));
      chk("rr0_tag", 64'(cdb_tag_out), 64'(10 + exp_src[k]));
      tick();
    end
    tick();

    // Saturation: units 0 and 1 push ten results each, honouring ready
    mon_q.delete();
    mon_en = 1'b1;
    s = '{0, 0};
    saw_low = '{1'b0, 1'b0};
    iter = 0;
    while ((s[0] < 10 || s[1] < 10) && iter < 200) begin
      for (int u = 0; u < 2; u++) begin
        if (!req_ready_out[u]) saw_low[u] = 1'b1;
        if (s[u] < 10 && req_ready_out[u]) begin
          drive(u, 4'(s[u] + 1), 32'h0001_0000 * (u + 1) + 32'(s[u]));
          s[u]++;
        end else begin
          req_valid_in[u] = 1'b0;
        end
      end
      tick();
      iter++;
    end
    idle();
    repeat (8) tick();
    mon_en = 1'b0;
    chk("sat_bounded", 64'(iter < 200), 64'd1);
    chk("sat_ready_low0", 64'(saw_low[0]), 64'd1);
    chk("sat_ready_low1", 64'(saw_low[1]), 64'd1);
    n = '{0, 0};
    alt = (mon_q.size() > 0) && (mon_q[0].src == 2'd0);
    for (int k = 0; k < mon_q.size(); k++) begin
      if (k > 0 && mon_q[k].src == mon_q[k-1].src) alt = 1'b0;
      if (mon_q[k].src < 2'd2) begin
        chk("sat_order_data", 64'(mon_q[k].data),
            64'(32'h0001_0000 * (32'(mon_q[k].src) + 1) + 32'(n[mon_q[k].src])));
        chk("sat_order_tag", 64'(mon_q[k].tag), 64'(n[mon_q[k].src] + 1));
        n[mon_q[k].src]++;
      end else begin
        chk("sat_src_range", 64'(mon_q[k].src), 64'd0);
      end
    end
    chk("sat_count0", 64'(n[0]), 64'd10);
    chk("sat_count1", 64'(n[1]), 64'd10);
    chk("sat_alternate", 64'(alt), 64'd1);

    // Rollback with FIFOs at counts 2,2,1; pointer starts at 2
    mon_q.delete();
    mon_en = 1'b1;
    drive(0, 4'd1, 32'hE1); drive(1, 4'd2, 32'hE2); drive(2, 4'd3, 32'hE3);
    tick(); idle();
    drive(0, 4'd4, 32'hE4); drive(1, 4'd5, 32'hE5);
    tick(); idle();
    drive(2, 4'd6, 32'hE6);
    tick(); idle();
    drive(0, 4'd7, 32'hE7);
    tick(); idle();
    drive(1, 4'd8, 32'hE8); drive(2, 4'd9, 32'hE9);
    tick(); idle();
    chk("rb_ready_full", 64'(req_ready_out), 64'b100);
    rob_rollback_in = 1'b1;
    drive(2, 4'd10, 32'hEA);
    tick();
    rob_rollback_in = 1'b0;
    idle();
    chk("rb_ready_after", 64'(req_ready_out), 64'b111);
    repeat (5) begin
      chk("rb_valid_low", 64'(cdb_valid_out), 64'd0);
      tick();
    end
    mon_en = 1'b0;
    rb_tags = '{4'd3, 4'd1, 4'd2, 4'd6};
    chk("rb_bcast_count", 64'(mon_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < mon_q.size(); k++)
      chk("rb_bcast_tag", 64'(mon_q[k].tag), 64'(rb_tags[k]));

    // rst together with rollback and a push, pointer at 1 beforehand
    drive(0, 4'd11, 32'hF1);
    tick(); idle();
    drive(1, 4'd12, 32'hF2); drive(2, 4'd13, 32'hF3);
    tick(); idle();
    rst = 1'b1;
    rob_rollback_in = 1'b1;
    drive(0, 4'd14, 32'hF4);
    tick();
    rst = 1'b0;
    rob_rollback_in = 1'b0;
    idle();
    chk("rst2_valid", 64'(cdb_valid_out), 64'd0);
    chk("rst2_tag",   64'(cdb_tag_out),   64'd0);
    chk("rst2_data",  64'(cdb_data_out),  64'd0);
    chk("rst2_extra", 64'(cdb_extra_out), 64'd0);
    chk("rst2_src",   64'(cdb_src_out),   64'd0);
    chk("rst2_ready", 64'(req_ready_out), 64'b111);
    drive(0, 4'd1, 32'hD1); drive(1, 4'd2, 32'hD2); drive(2, 4'd3, 32'hD3);
    tick(); idle(); tick();
    chk("rst2_first_src", 64'(cdb_src_out), 64'd0);
    chk("rst2_first_tag", 64'(cdb_tag_out), 64'd1);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
